// File: rtl/extrema_pkg.sv
// extrema_pkg: shared FSM encoding and default sizing for the extrema tracker
package extrema_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10
    } state_t;
    localparam int DEF_WIDTH = 5;
    localparam int DEF_WIN = 8;
endpackage

// File: rtl/extrema_tracker_if.sv
// extrema_tracker_if: sample stream in (valid/ready) and window result out (valid/ack)
// master: sample source and result consumer; slave: extrema_tracker
// EXTREMA_IDX_EN adds max_idx
interface extrema_tracker_if import extrema_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WIN = DEF_WIN
);
    localparam int CW = $clog2(WIN + 1);
    logic start;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] in_data;
    logic out_valid;
    logic out_ack;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] min_val;
    logic [CW-1:0] gt_cnt;
    logic [CW-1:0] eq_cnt;
    logic busy;
`ifdef EXTREMA_IDX_EN
    logic [CW-1:0] max_idx;
`endif
    modport master (
`ifdef EXTREMA_IDX_EN
        input max_idx,
`endif
        output start, in_valid, in_data, out_ack,
        input in_ready, out_valid, max_val, min_val, gt_cnt, eq_cnt, busy
    );
    modport slave (
`ifdef EXTREMA_IDX_EN
        output max_idx,
`endif
        input start, in_valid, in_data, out_ack,
        output in_ready, out_valid, max_val, min_val, gt_cnt, eq_cnt, busy
    );
endinterface

// File: rtl/mag_cmp_n.sv
// mag_cmp_n: unsigned magnitude comparator, exactly one of agtb/aeqb/altb is high
// Ports: a, b (WIDTH-bit operands); agtb, aeqb, altb (compare results)
module mag_cmp_n #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic agtb,
    output logic aeqb,
    output logic altb
);
    assign agtb = a > b;
    assign aeqb = a == b;
    assign altb = a < b;
endmodule

// File: rtl/extrema_tracker.sv
// extrema_tracker: per-window running max/min with new-max and tie-with-max counts
// Ports: clk, rst (async active-high), bus (extrema_tracker_if.slave)
// EXTREMA_IDX_EN adds max_idx: window index of the sample that last raised the max
module extrema_tracker import extrema_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WIN = DEF_WIN
) (
    input logic clk,
    input logic rst,
    extrema_tracker_if.slave bus
);
    localparam int CW = $clog2(WIN + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic accept, clear, first, last, raise, tie, lower;
    logic unused_max_lt, unused_min_gt, unused_min_eq;
    mag_cmp_n #(.WIDTH(WIDTH)) u_max_cmp (
        .a(bus.in_data), .b(bus.max_val), .agtb(raise), .aeqb(tie), .altb(unused_max_lt)
    );
    mag_cmp_n #(.WIDTH(WIDTH)) u_min_cmp (
        .a(bus.in_data), .b(bus.min_val), .agtb(unused_min_gt), .aeqb(unused_min_eq), .altb(lower)
    );
    // accept is taken from state directly so it does not loop through in_ready
    assign accept = bus.in_valid & (state == ST_COLLECT);
    assign clear = (state == ST_IDLE) & bus.start;
    assign first = cnt == '0;
    assign last = cnt == CW'(WIN - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        bus.in_ready = state == ST_COLLECT;
        bus.out_valid = state == ST_DONE;
        bus.busy = state != ST_IDLE;
        state_n = clear ? ST_COLLECT :
                  (accept && last) ? ST_DONE :
                  (state == ST_DONE && bus.out_ack) ? ST_IDLE :
                  (state == ST_COLLECT || state == ST_DONE) ? state : ST_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            bus.max_val <= '0;
            bus.min_val <= '0;
            bus.gt_cnt <= '0;
            bus.eq_cnt <= '0;
`ifdef EXTREMA_IDX_EN
            bus.max_idx <= '0;
`endif
        end else if (clear) begin
            cnt <= '0;
            bus.max_val <= '0;
            bus.min_val <= '0;
            bus.gt_cnt <= '0;
            bus.eq_cnt <= '0;
`ifdef EXTREMA_IDX_EN
            bus.max_idx <= '0;
`endif
        end else if (accept) begin
            cnt <= cnt + CW'(1);
            if (first) begin
                bus.max_val <= bus.in_data;
                bus.min_val <= bus.in_data;
                bus.gt_cnt <= CW'(1);
`ifdef EXTREMA_IDX_EN
                bus.max_idx <= '0;
`endif
            end else begin
                if (raise) begin
                    bus.max_val <= bus.in_data;
                    bus.gt_cnt <= bus.gt_cnt + CW'(1);
`ifdef EXTREMA_IDX_EN
                    bus.max_idx <= cnt;
`endif
                end
                if (tie)
                    bus.eq_cnt <= bus.eq_cnt + CW'(1);
                if (lower)
                    bus.min_val <= bus.in_data;
            end
        end
    end
endmodule
